id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Consumer end of the decode-stage output bundles: the ID/EX pipeline register plus hazard control. It sits between the decode stage and the ALU/EX stage.
- Each cycle it latches the decode data bundle, the control bundle, the PC and the register-file read values into EX-side registers.
- It detects load-use and jump-register hazards, holds the decode stage and inserts control bubbles, and honours flushes from EX.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- id_valid  input  1  decode bundle valid this cycle
- id_pc  input  32  PC of the instruction in ID
- id_data  input  116  {JT[31:0], Shamt[4:0], Rs[4:0], Rt[4:0], Rd[4:0], Ext_out[31:0], LU_out[31:0]}, MSB first
- id_ctrl  input  20  {RegDst[1:0], RegWr, ALUSrc1, ALUSrc2, ALUFun[5:0], Sign, MemWr, MemRd, MemtoReg[1:0], Jump_I, Jump_R, ID_EXP, ID_IRQ}, MSB first
- id_rs_data  input  32  register-file read value for Rs
- id_rt_data  input  32  register-file read value for Rt
- ex_flush  input  1  EX resolved a taken branch/redirect; kill the ID instruction
- id_hold  output  1  hold IF/ID (PC and instruction) this cycle
- ex_valid  output  1  EX register holds a real instruction
- ex_pc  output  32  latched PC
- ex_data  output  116  latched id_data
- ex_ctrl  output  20  latched id_ctrl; all-zero for a bubble
- ex_rs_data  output  32  latched Rs value
- ex_rt_data  output  32  latched Rt value
- ex_dest  output  5  write register of EX instruction
- stall_count  output  STALL_CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (asynchronous): every output register is 0, the FSM is in RUN, and stall_count is 0. id_hold is 0 during reset.
- ex_dest is decoded combinationally from the registered ex_ctrl.RegDst:
  - 00 -> Rd
  - 01 -> Rt
  - 10 -> 31
  - 11 -> 26
  - ex_dest is forced to 0 when ex_valid=0.
- Hazard terms, combinational from the ID inputs and the EX registers, all qualified by id_valid and ex_valid:
  - lu = ex_ctrl.MemRd & ex_dest!=0 & (ex_dest==id.Rs | ex_dest==id.Rt)
  - jr = id_ctrl.Jump_R & ex_ctrl.RegWr & ex_dest!=0 & ex_dest==id.Rs
  - jr_ld = jr & ex_ctrl.MemRd
- FSM states: RUN and STALL2.
  - RUN: if ex_flush, load a bubble and stay in RUN. Else if jr_ld, assert id_hold, load a bubble and go to STALL2. Else if lu or jr, assert id_hold, load a bubble and stay in RUN; re-detection happens next cycle. Else load the ID bundle.
  - STALL2: assert id_hold, load a bubble and return to RUN. If ex_flush arrives in STALL2, drop id_hold, load a bubble and go to RUN.
- Loading the ID bundle means: ex_valid<=id_valid and all fields are copied. If id_valid=0, ex_ctrl<=0.
- Loading a bubble means: ex_valid<=0 and ex_ctrl<=0. Other data fields may keep their old values but are don't-care.
- ex_flush has priority over every stall condition. id_hold is never asserted in a cycle where ex_flush=1.
- ID_IRQ/ID_EXP instructions carry no register dependence. They stall only when lu matches the Rs/Rt fields present in the bundle; no special case applies.
- Latency: exactly 1 cycle from ID to EX when no hazard occurs. Load-use costs 1 bubble; jr-after-load costs 2 bubbles; jr-after-ALU-write costs 1 bubble.
- stall_count increments on every cycle with id_hold=1 and saturates at all-ones without wrapping.
- id_hold is combinational from the current inputs, FSM state and EX registers. No combinational path exists from id_hold back into the hazard terms.

Test Plan:
- Reset and pass-through: assert reset mid-stream -> all outputs go to 0 immediately. After release, drive a valid ALU instruction with id_ctrl=20'h0A5F3 and id_pc=32'h0040_0010 -> ex_ctrl=20'h0A5F3 and ex_pc=32'h0040_0010 on the next edge; id_hold=0 throughout.
- Load-use: EX holds lw with RegDst=01 and Rt=8; ID has add with Rs=8 -> id_hold=1 for 1 cycle, ex_ctrl=0 and ex_valid=0 next cycle, then the add enters EX; stall_count=1.
- jr after lw: EX holds lw writing $31; ID has jr with Rs=31 -> id_hold=1 for 2 consecutive cycles, 2 bubbles enter EX, then jr enters EX; stall_count=2.
- Flush beats stall: load-use condition present and ex_flush=1 in the same cycle -> id_hold=0, bubble loaded, FSM in RUN, stall_count unchanged.
- $0 exemption: EX holds lw with dest 0; ID reads Rs=0 -> no stall; instruction advances in 1 cycle.
- Saturation: preload stall_count to 16'hFFFE, then force 3 stall cycles -> stall_count reads 16'hFFFF and holds.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use / jump-register hazard control and EX-driven flush.
// Latency 1 cycle ID->EX; hazards hold ID (id_hold) and insert bubbles (1 for load-use or jr-after-ALU, 2 for jr-after-load).
module id_ex_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [31:0]            id_pc,
    input  logic [115:0]           id_data,
    input  logic [19:0]            id_ctrl,
    input  logic [31:0]            id_rs_data,
    input  logic [31:0]            id_rt_data,
    input  logic                   ex_flush,
    output logic                   id_hold,
    output logic                   ex_valid,
    output logic [31:0]            ex_pc,
    output logic [115:0]           ex_data,
    output logic [19:0]            ex_ctrl,
    output logic [31:0]            ex_rs_data,
    output logic [31:0]            ex_rt_data,
    output logic [4:0]             ex_dest,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic {RUN, STALL2} state_t;
    state_t state;

    logic [4:0] id_rs, id_rt, ex_rt, ex_rd;
    logic       id_jump_r, ex_regwr, ex_memrd;
    logic       both_valid, dest_live, lu, jr, jr_ld;

    assign id_rs     = id_data[78:74];
    assign id_rt     = id_data[73:69];
    assign ex_rt     = ex_data[73:69];
    assign ex_rd     = ex_data[68:64];
    assign id_jump_r = id_ctrl[2];
    assign ex_regwr  = ex_ctrl[17];
    assign ex_memrd  = ex_ctrl[6];

    always_comb begin
        ex_dest = 5'd0;
        if (ex_valid) begin
            case (ex_ctrl[19:18])
                2'b00:   ex_dest = ex_rd;
                2'b01:   ex_dest = ex_rt;
                2'b10:   ex_dest = 5'd31;
                default: ex_dest = 5'd26;
            endcase
        end
    end

    // Hazard terms look only at ID inputs and EX registers, never at id_hold.
    assign both_valid = id_valid & ex_valid;
    assign dest_live  = (ex_dest != 5'd0);
    assign lu    = both_valid & ex_memrd & dest_live & ((ex_dest == id_rs) | (ex_dest == id_rt));
    assign jr    = both_valid & id_jump_r & ex_regwr & dest_live & (ex_dest == id_rs);
    assign jr_ld = jr & ex_memrd;

    always_comb begin
        id_hold = 1'b0;
        if (!reset && !ex_flush) begin
            if (state == STALL2)
                id_hold = 1'b1;
            else
                id_hold = lu | jr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_data     <= '0;
            ex_ctrl     <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            stall_count <= '0;
        end else begin
            if (id_hold && (stall_count != {STALL_CNT_W{1'b1}}))
                stall_count <= stall_count + 1'b1;

            // Every path except a clean RUN cycle loads a bubble.
            if (state == RUN && !ex_flush && !lu && !jr) begin
                ex_valid   <= id_valid;
                ex_pc      <= id_pc;
                ex_data    <= id_data;
                ex_ctrl    <= id_valid ? id_ctrl : 20'd0;
                ex_rs_data <= id_rs_data;
                ex_rt_data <= id_rt_data;
            end else begin
                ex_valid <= 1'b0;
                ex_ctrl  <= 20'd0;
            end

            case (state)
                RUN:     state <= (!ex_flush && jr_ld) ? STALL2 : RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, pass-through, hazards, flush priority, $0 exemption, saturation.
module tb_id_ex_stage;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         id_valid = 1'b0;
    logic [31:0]  id_pc = '0;
    logic [115:0] id_data = '0;
    logic [19:0]  id_ctrl = '0;
    logic [31:0]  id_rs_data = '0;
    logic [31:0]  id_rt_data = '0;
    logic         ex_flush = 1'b0;

    logic         id_hold, ex_valid;
    logic [31:0]  ex_pc, ex_rs_data, ex_rt_data;
    logic [115:0] ex_data;
    logic [19:0]  ex_ctrl;
    logic [4:0]   ex_dest;
    logic [15:0]  stall_count;

    logic         s_hold, s_valid;
    logic [31:0]  s_pc, s_rs, s_rt;
    logic [115:0] s_data;
    logic [19:0]  s_ctrl;
    logic [4:0]   s_dest;
    logic [1:0]   s_count;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_data(id_data),
        .id_ctrl(id_ctrl), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .ex_flush(ex_flush),
        .id_hold(id_hold), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_data(ex_data), .ex_ctrl(ex_ctrl),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_dest(ex_dest), .stall_count(stall_count)
    );

    // Narrow-counter twin sees the same stimulus so saturation is reachable in a few stalls.
    id_ex_stage #(.STALL_CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_data(id_data),
        .id_ctrl(id_ctrl), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .ex_flush(ex_flush),
        .id_hold(s_hold), .ex_valid(s_valid), .ex_pc(s_pc), .ex_data(s_data), .ex_ctrl(s_ctrl),
        .ex_rs_data(s_rs), .ex_rt_data(s_rt), .ex_dest(s_dest), .stall_count(s_count)
    );

    function automatic logic [115:0] mk_data(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {32'h0040_1000, 5'd0, rs, rt, rd, 32'h1234_5678, 27'd0, rd};
    endfunction

    function automatic logic [19:0] mk_ctrl(input logic [1:0] regdst, input logic regwr,
                                            input logic memrd, input logic jump_r);
        return {regdst, regwr, 2'b01, 6'h00, 1'b0, 1'b0, memrd, memrd, 1'b0, 1'b0, jump_r, 2'b00};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [115:0] d, input logic [19:0] c);
        id_valid   = v;
        id_pc      = pc;
        id_data    = d;
        id_ctrl    = c;
        id_rs_data = pc ^ 32'hA5A5_0000;
        id_rt_data = pc ^ 32'h0000_5A5A;
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        reset = 1'b0;
        drive(1'b1, 32'h0040_0000, mk_data(5'd1, 5'd2, 5'd3), mk_ctrl(2'b00, 1'b1, 1'b0, 1'b0));
        step();
        total++; if (ex_valid !== 1'b1) $display("FAIL pre_reset_valid got %0h exp 1", ex_valid); else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++; if (ex_valid !== 1'b0) $display("FAIL reset_valid got %0h exp 0", ex_valid); else passed++;
        total++; if (ex_ctrl !== 20'd0) $display("FAIL reset_ctrl got %h exp 00000", ex_ctrl); else passed++;
        total++; if (ex_pc !== 32'd0) $display("FAIL reset_pc got %h exp 00000000", ex_pc); else passed++;
        total++; if (ex_data !== 116'd0) $display("FAIL reset_data got %h exp 0", ex_data); else passed++;
        total++; if (id_hold !== 1'b0) $display("FAIL reset_hold got %0h exp 0", id_hold); else passed++;
        total++; if (stall_count !== 16'd0) $display("FAIL reset_count got %h exp 0000", stall_count); else passed++;
        step();
        reset = 1'b0;
    endtask

    task automatic test_pass_through();
        drive(1'b1, 32'h0040_0010, mk_data(5'd1, 5'd2, 5'd5), 20'h0A5F3);
        total++; if (id_hold !== 1'b0) $display("FAIL pt_hold_pre got %0h exp 0", id_hold); else passed++;
        step();
        total++; if (ex_ctrl !== 20'h0A5F3) $display("FAIL pt_ctrl got %h exp 0a5f3", ex_ctrl); else passed++;
        total++; if (ex_pc !== 32'h0040_0010) $display("FAIL pt_pc got %h exp 00400010", ex_pc); else passed++;
        total++; if (ex_valid !== 1'b1) $display("FAIL pt_valid got %0h exp 1", ex_valid); else passed++;
        total++; if (ex_rs_data !== 32'hA5E5_0010) $display("FAIL pt_rs_data got %h exp a5e50010", ex_rs_data); else passed++;
        total++; if (ex_dest !== 5'd5) $display("FAIL pt_dest_rd got %0d exp 5", ex_dest); else passed++;
        total++; if (id_hold !== 1'b0) $display("FAIL pt_hold_post got %0h exp 0", id_hold); else passed++;
        drive(1'b0, 32'h0040_0014, mk_data(5'd1, 5'd2, 5'd6), mk_ctrl(2'b00, 1'b1, 1'b0, 1'b0));
        step();
        total++; if (ex_valid !== 1'b0) $display("FAIL invalid_valid got %0h exp 0", ex_valid); else passed++;
        total++; if (ex_ctrl !== 20'd0) $display("FAIL invalid_ctrl got %h exp 00000", ex_ctrl); else passed++;
        total++; if (ex_dest !== 5'd0) $display("FAIL invalid_dest got %0d exp 0", ex_dest); else passed++;
    endtask

    task automatic test_load_use();
        drive(1'b1, 32'h0040_0020, mk_data(5'd3, 5'd8, 5'd0), mk_ctrl(2'b01, 1'b1, 1'b1, 1'b0));
        step();
        total++; if (ex_dest !== 5'd8) $display("FAIL lu_lw_dest got %0d exp 8", ex_dest); else passed++;
        drive(1'b1, 32'h0040_0024, mk_data(5'd8, 5'd9, 5'd10), mk_ctrl(2'b00, 1'b1, 1'b0, 1'b0));
        total++; if (id_hold !== 1'b1) $display("FAIL lu_hold got %0h exp 1", id_hold); else passed++;
        step();
        total++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble_valid got %0h exp 0", ex_valid); else passed++;
        total++; if (ex_ctrl !== 20'd0) $display("FAIL lu_bubble_ctrl got %h exp 00000", ex_ctrl); else passed++;
        total++; if (id_hold !== 1'b0) $display("FAIL lu_hold_release got %0h exp 0", id_hold); else passed++;
        total++; if (stall_count !== 16'd1) $display("FAIL lu_count got %0d exp 1", stall_count); else passed++;
        step();
        total++; if (ex_valid !== 1'b1 || ex_pc !== 32'h0040_0024) $display("FAIL lu_add_enter got %0h/%h exp 1/00400024", ex_valid, ex_pc); else passed++;
        total++; if (ex_dest !== 5'd10) $display("FAIL lu_add_dest got %0d exp 10", ex_dest); else passed++;
    endtask

    task automatic test_jr_after_lw();
        drive(1'b1, 32'h0040_0030, mk_data(5'd4, 5'd7, 5'd0), mk_ctrl(2'b10, 1'b1, 1'b1, 1'b0));
        step();
        total++; if (ex_dest !== 5'd31) $display("FAIL jrld_lw_dest got %0d exp 31", ex_dest); else passed++;
        drive(1'b1, 32'h0040_0034, mk_data(5'd31, 5'd0, 5'd0), mk_ctrl(2'b00, 1'b0, 1'b0, 1'b1));
        total++; if (id_hold !== 1'b1) $display("FAIL jrld_hold1 got %0h exp 1", id_hold); else passed++;
        step();
        total++; if (ex_valid !== 1'b0 || ex_ctrl !== 20'd0) $display("FAIL jrld_bubble1 got %0h/%h exp 0/00000", ex_valid, ex_ctrl); else passed++;
        total++; if (id_hold !== 1'b1) $display("FAIL jrld_hold2 got %0h exp 1", id_hold); else passed++;
        step();
        total++; if (ex_valid !== 1'b0 || ex_ctrl !== 20'd0) $display("FAIL jrld_bubble2 got %0h/%h exp 0/00000", ex_valid, ex_ctrl); else passed++;
        total++; if (id_hold !== 1'b0) $display("FAIL jrld_hold3 got %0h exp 0", id_hold); else passed++;
        total++; if (stall_count !== 16'd3) $display("FAIL jrld_count got %0d exp 3", stall_count); else passed++;
        step();
        total++; if (ex_valid !== 1'b1 || ex_pc !== 32'h0040_0034) $display("FAIL jrld_jr_enter got %0h/%h exp 1/00400034", ex_valid, ex_pc); else passed++;
    endtask

    task automatic test_jr_after_alu();
        drive(1'b1, 32'h0040_0040, mk_data(5'd1, 5'd2, 5'd12), mk_ctrl(2'b00, 1'b1, 1'b0, 1'b0));
        step();
        drive(1'b1, 32'h0040_0044, mk_data(5'd12, 5'd0, 5'd0), mk_ctrl(2'b00, 1'b0, 1'b0, 1'b1));
        total++; if (id_hold !== 1'b1) $display("FAIL jralu_hold got %0h exp 1", id_hold); else passed++;
        step();
        total++; if (ex_valid !== 1'b0 || id_hold !== 1'b0) $display("FAIL jralu_one_bubble got %0h/%0h exp 0/0", ex_valid, id_hold); else passed++;
        total++; if (stall_count !== 16'd4) $display("FAIL jralu_count got %0d exp 4", stall_count); else passed++;
        step();
        total++; if (ex_pc !== 32'h0040_0044 || ex_valid !== 1'b1) $display("FAIL jralu_enter got %h/%0h exp 00400044/1", ex_pc, ex_valid); else passed++;
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h0040_0050, mk_data(5'd3, 5'd8, 5'd0), mk_ctrl(2'b01, 1'b1, 1'b1, 1'b0));
        step();
        drive(1'b1, 32'h0040_0054, mk_data(5'd8, 5'd9, 5'd10), mk_ctrl(2'b00, 1'b1, 1'b0, 1'b0));
        ex_flush = 1'b1;
        #1;
        total++; if (id_hold !== 1'b0) $display("FAIL flush_hold got %0h exp 0", id_hold); else passed++;
        step();
        ex_flush = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b0 || ex_ctrl !== 20'd0) $display("FAIL flush_bubble got %0h/%h exp 0/00000", ex_valid, ex_ctrl); else passed++;
        total++; if (stall_count !== 16'd4) $display("FAIL flush_count got %0d exp 4", stall_count); else passed++;
        total++; if (id_hold !== 1'b0) $display("FAIL flush_run got %0h exp 0", id_hold); else passed++;
        step();
        total++; if (ex_valid !== 1'b1 || ex_pc !== 32'h0040_0054) $display("FAIL flush_next got %0h/%h exp 1/00400054", ex_valid, ex_pc); else passed++;
        // Flush arriving while in the second jr-after-load stall cycle.
        drive(1'b1, 32'h0040_0058, mk_data(5'd4, 5'd7, 5'd0), mk_ctrl(2'b10, 1'b1, 1'b1, 1'b0));
        step();
        drive(1'b1, 32'h0040_005C, mk_data(5'd31, 5'd0, 5'd0), mk_ctrl(2'b00, 1'b0, 1'b0, 1'b1));
        step();
        ex_flush = 1'b1;
        #1;
        total++; if (id_hold !== 1'b0) $display("FAIL flush_stall2_hold got %0h exp 0", id_hold); else passed++;
        step();
        ex_flush = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b0 || id_hold !== 1'b0) $display("FAIL flush_stall2_run got %0h/%0h exp 0/0", ex_valid, id_hold); else passed++;
        total++; if (stall_count !== 16'd5) $display("FAIL flush_stall2_count got %0d exp 5", stall_count); else passed++;
        step();
        total++; if (ex_valid !== 1'b1 || ex_pc !== 32'h0040_005C) $display("FAIL flush_stall2_next got %0h/%h exp 1/0040005c", ex_valid, ex_pc); else passed++;
    endtask

    task automatic test_zero_exempt();
        drive(1'b1, 32'h0040_0060, mk_data(5'd3, 5'd0, 5'd0), mk_ctrl(2'b01, 1'b1, 1'b1, 1'b0));
        step();
        drive(1'b1, 32'h0040_0064, mk_data(5'd0, 5'd9, 5'd11), mk_ctrl(2'b00, 1'b1, 1'b0, 1'b0));
        total++; if (id_hold !== 1'b0) $display("FAIL zero_hold got %0h exp 0", id_hold); else passed++;
        step();
        total++; if (ex_valid !== 1'b1 || ex_pc !== 32'h0040_0064) $display("FAIL zero_advance got %0h/%h exp 1/00400064", ex_valid, ex_pc); else passed++;
        total++; if (stall_count !== 16'd5) $display("FAIL zero_count got %0d exp 5", stall_count); else passed++;
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        step();
        reset = 1'b0;
        // jr after lw: two stalls leave the 2-bit counter one below all-ones.
        drive(1'b1, 32'h0040_0070, mk_data(5'd4, 5'd7, 5'd0), mk_ctrl(2'b10, 1'b1, 1'b1, 1'b0));
        step();
        drive(1'b1, 32'h0040_0074, mk_data(5'd31, 5'd0, 5'd0), mk_ctrl(2'b00, 1'b0, 1'b0, 1'b1));
        step();
        step();
        total++; if (s_count !== 2'd2) $display("FAIL sat_preload got %0d exp 2", s_count); else passed++;
        step();
        drive(1'b1, 32'h0040_0078, mk_data(5'd4, 5'd7, 5'd0), mk_ctrl(2'b10, 1'b1, 1'b1, 1'b0));
        step();
        drive(1'b1, 32'h0040_007C, mk_data(5'd31, 5'd0, 5'd0), mk_ctrl(2'b00, 1'b0, 1'b0, 1'b1));
        step();
        step();
        step();
        drive(1'b1, 32'h0040_0080, mk_data(5'd3, 5'd8, 5'd0), mk_ctrl(2'b01, 1'b1, 1'b1, 1'b0));
        step();
        drive(1'b1, 32'h0040_0084, mk_data(5'd2, 5'd8, 5'd1), mk_ctrl(2'b00, 1'b1, 1'b0, 1'b0));
        step();
        total++; if (s_count !== 2'd3) $display("FAIL sat_hold got %0d exp 3", s_count); else passed++;
        total++; if (stall_count !== 16'd5) $display("FAIL sat_wide_count got %0d exp 5", stall_count); else passed++;
        step();
        total++; if (s_count !== 2'd3) $display("FAIL sat_stable got %0d exp 3", s_count); else passed++;
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_use();
        test_jr_after_lw();
        test_jr_after_alu();
        test_flush();
        test_zero_exempt();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
